// File: rtl/clock_button_conditioner.sv
// Button front end for the clock UI: per-button synchronizer, integrating debouncer,
// one-cycle active-low press pulse, long-press detect and optional auto-repeat.
module clock_button_conditioner #(
    parameter int unsigned         N_BTN           = 3,
    parameter int unsigned         DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned         LONG_CYCLES     = 50_000_000,
    parameter int unsigned         REPEAT_CYCLES   = 10_000_000,
    parameter logic [N_BTN-1:0]    REPEAT_MASK     = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic [N_BTN-1:0] btn_pulse_n_o,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_long_o
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
    localparam int unsigned RptW  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES - 1);
    localparam logic [RptW-1:0]  RptMax  = RptW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHeld, StLong, StRepeat} state_e;

    logic [N_BTN-1:0] s1_q, s2_q;

    // Two-flop synchronizer for the asynchronous raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw_i;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [DbW-1:0]   db_cnt_q, db_cnt_d;
        logic             level_q, level_d;
        state_e           state_q, state_d;
        logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
        logic [RptW-1:0]  rpt_cnt_q, rpt_cnt_d;
        logic             pulse_n_q, long_q;
        logic             press, long_evt;

        // Integrating debouncer: any single agreeing cycle restarts the count
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            if (s2_q[i] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DbMax) begin
                level_d  = s2_q[i];
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Press / long-press / repeat FSM driven by the debounced level
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            rpt_cnt_d  = rpt_cnt_q;
            press      = 1'b0;
            long_evt   = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (level_q) begin
                        press      = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = StHeld;
                    end
                end
                StHeld: begin
                    if (!level_q) begin
                        state_d = StIdle;
                    end else if (hold_cnt_q == HoldMax) begin
                        long_evt = 1'b1;
                        if (REPEAT_MASK[i]) begin
                            press     = 1'b1;
                            rpt_cnt_d = '0;
                            state_d   = StRepeat;
                        end else begin
                            state_d = StLong;
                        end
                    end else begin
                        // Only counts below the threshold, so it can never wrap
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                StLong: begin
                    if (!level_q) state_d = StIdle;
                end
                StRepeat: begin
                    if (!level_q) begin
                        state_d = StIdle;
                    end else if (rpt_cnt_q == RptMax) begin
                        press     = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // State registers; outputs are registered to keep input->output paths sequential
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt_q   <= '0;
                level_q    <= 1'b0;
                state_q    <= StIdle;
                hold_cnt_q <= '0;
                rpt_cnt_q  <= '0;
                pulse_n_q  <= 1'b1;
                long_q     <= 1'b0;
            end else begin
                db_cnt_q   <= db_cnt_d;
                level_q    <= level_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                rpt_cnt_q  <= rpt_cnt_d;
                pulse_n_q  <= ~press;
                long_q     <= long_evt;
            end
        end

        assign btn_pulse_n_o[i] = pulse_n_q;
        assign btn_level_o[i]   = level_q;
        assign btn_long_o[i]    = long_q;
    end

endmodule
